// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: counter encoding,
// BTB entry layout and the saturating counter update.
package bp_pkg;

  localparam int BP_PC_W    = 9;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_PC_W - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_ctr_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    logic                is_jump;
    bp_ctr_e             ctr;
  } bp_entry_t;

  localparam bp_ctr_e BP_CTR_RESET = WNT;

  function automatic bp_ctr_e bp_ctr_next(input bp_ctr_e ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : bp_ctr_e'(ctr + 2'd1);
    else       return (ctr == SNT) ? SNT : bp_ctr_e'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// BTB/BHT entry array: one combinational read port for fetch lookup and one
// synchronous read-modify-write training port driven by the EX resolution.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx,
  output bp_entry_t           rd_entry,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [BP_TAG_W-1:0] wr_tag,
  input  logic                wr_taken,
  input  logic [BP_PC_W-1:0]  wr_target,
  input  logic                wr_is_jump
);

  localparam bp_entry_t RESET_ENTRY = '{
    valid:   1'b0,
    tag:     '0,
    target:  '0,
    is_jump: 1'b0,
    ctr:     BP_CTR_RESET
  };

  bp_entry_t mem [ENTRIES];
  bp_entry_t wr_cur;
  logic      wr_hit;

  // Read-before-write: a lookup in the training cycle sees the old entry.
  assign rd_entry = mem[rd_idx];
  assign wr_cur   = mem[wr_idx];
  assign wr_hit   = wr_cur.valid && (wr_cur.tag == wr_tag);

  // NOTE: every entry is reset because the counters must start weakly
  // not-taken; this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= RESET_ENTRY;
    end else if (wr_en) begin
      if (wr_hit) begin
        mem[wr_idx].ctr <= bp_ctr_next(wr_cur.ctr, wr_taken);
        if (wr_taken) begin
          mem[wr_idx].target  <= wr_target;
          mem[wr_idx].is_jump <= wr_is_jump;
        end
      end else if (wr_taken) begin
        mem[wr_idx] <= '{
          valid:   1'b1,
          tag:     wr_tag,
          target:  wr_target,
          is_jump: wr_is_jump,
          ctr:     WT
        };
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor and EX-stage resolver. Optional performance
// counters are built only when BP_PERF_CNT_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = BP_PC_W,
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  bp_entry_t        rd_entry;
  logic             hit;
  logic             upd;
  logic             unused_if_pc_lsbs;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  assign unused_if_pc_lsbs = ^if_pc[1:0];

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (if_idx),
    .rd_entry   (rd_entry),
    .wr_en      (upd && !reset),
    .wr_idx     (ex_idx),
    .wr_tag     (ex_tag),
    .wr_taken   (ex_taken),
    .wr_target  (ex_target),
    .wr_is_jump (ex_is_jump)
  );

  // Outputs are forced low during reset because the array only clears on the edge.
  assign hit         = rd_entry.valid && (rd_entry.tag == if_tag);
  assign pred_taken  = !reset && if_valid && hit &&
                       (rd_entry.is_jump || (rd_entry.ctr inside {WT, ST}));
  assign pred_target = pred_taken ? rd_entry.target : '0;

  assign upd        = ex_valid && (ex_is_branch || ex_is_jump);
  assign mispredict = !reset && upd &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = !mispredict ? '0 :
                       ex_taken    ? ex_target : ex_pc + PC_W'(4);

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_cnt, mp_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (upd)        br_cnt <= br_cnt + 32'd1;
      if (mispredict) mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign perf_branches    = br_cnt;
  assign perf_mispredicts = mp_cnt;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
